// File: rtl/triangle_pkg.sv
// Shared types for the double-buffered triangle list: bank lifecycle states,
// default coordinate format and the packed triangle type.
package triangle_pkg;

  localparam int TRI_WI    = 2;
  localparam int TRI_WF    = 2;
  localparam int TRI_NV    = 3;
  localparam int TRI_NC    = 3;
  localparam int TRI_DEPTH = 4;
  localparam int TRI_W     = TRI_WI + TRI_WF;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2,
    READ  = 2'd3
  } bank_state_e;

  typedef logic [TRI_NV-1:0][TRI_NC-1:0][TRI_W-1:0] tri_t;

  function automatic logic bank_writable(input bank_state_e s);
    return (s == EMPTY) || (s == FILL);
  endfunction

  function automatic logic bank_committed(input bank_state_e s);
    return (s == FULL) || (s == READ);
  endfunction

endpackage

// File: rtl/triangle_bank_ram.sv
// Two-bank triangle storage: one synchronous write port, one asynchronous
// read port, addressed as bank*DEPTH + index.
module triangle_bank_ram #(
  parameter  int DW    = 36,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(2 * DEPTH)
) (
  input  logic          Clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2*DEPTH];

  // NOTE: the array has no reset; contents are only visible after being written,
  // and leaving it unreset lets synthesis map it onto plain storage.
  always_ff @(posedge Clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Addresses past the last entry only occur while the read side is idle.
  assign rdata_o = (int'(raddr_i) < 2 * DEPTH) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/triangle_list_pingpong.sv
// Double-buffered triangle list: the producer fills one bank while the
// rasterizer reads (and may replay) the other.
module triangle_list_pingpong
  import triangle_pkg::*;
#(
  parameter  int WI    = TRI_WI,
  parameter  int WF    = TRI_WF,
  parameter  int NV    = TRI_NV,
  parameter  int NC    = TRI_NC,
  parameter  int DEPTH = TRI_DEPTH,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int W     = WI + WF
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [NV-1:0][NC-1:0][W-1:0]  wr_tri,
  input  logic                          wr_commit,
  output logic [CW-1:0]                 wr_count,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [NV-1:0][NC-1:0][W-1:0]  rd_tri,
  output logic                          rd_last,
  input  logic                          rd_rewind,
  input  logic                          rd_release,
  output logic [1:0]                    frames_ready,
  output logic                          cmd_err
);

  localparam int DW = NV * NC * W;
  localparam int AW = $clog2(2 * DEPTH);

  typedef logic [NV-1:0][NC-1:0][W-1:0] tri_local_t;

  bank_state_e   bs_q [2];
  bank_state_e   bs_d [2];
  logic [CW-1:0] len_q [2];
  logic [CW-1:0] len_d [2];
  logic          wb_q, wb_d;
  logic          rb_q, rb_d;
  logic [CW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] rptr_q, rptr_d;
  logic          cmd_err_q, cmd_err_d;

  bank_state_e   wbank_s, rbank_s;
  logic [CW-1:0] rlen;
  logic          wr_fire, rd_fire, commit_ok;
  logic [AW-1:0] waddr, raddr;
  tri_local_t    ram_rdata;

  assign wbank_s = bs_q[wb_q];
  assign rbank_s = bs_q[rb_q];
  assign rlen    = len_q[rb_q];

  assign wr_ready  = bank_writable(wbank_s) && (wptr_q < CW'(DEPTH));
  assign wr_fire   = wr_valid && wr_ready;
  // An empty bank may only be committed together with its first write.
  assign commit_ok = wr_commit && ((wbank_s == FILL) || ((wbank_s == EMPTY) && wr_fire));

  assign rd_valid = (rbank_s == READ) && (rptr_q < rlen);
  assign rd_last  = rd_valid && (rptr_q == rlen - CW'(1));
  assign rd_fire  = rd_valid && rd_ready;

  assign waddr = AW'(int'(wb_q) * DEPTH + int'(wptr_q));
  assign raddr = AW'(int'(rb_q) * DEPTH + int'(rptr_q));

  triangle_bank_ram #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_ram (
    .Clk     (Clk),
    .we_i    (wr_fire),
    .waddr_i (waddr),
    .wdata_i (wr_tri),
    .raddr_i (raddr),
    .rdata_o (ram_rdata)
  );

  // NOTE: every next-state signal takes its hold value first so no path through
  // this block leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    bs_d      = bs_q;
    len_d     = len_q;
    wb_d      = wb_q;
    wptr_d    = wptr_q;
    rb_d      = rb_q;
    rptr_d    = rptr_q;
    cmd_err_d = cmd_err_q;

    // Write side only ever touches a bank that is EMPTY or FILL.
    if (commit_ok) begin
      len_d[wb_q] = wptr_q + CW'(wr_fire);
      bs_d[wb_q]  = FULL;
      wb_d        = ~wb_q;
      wptr_d      = '0;
    end else if (wr_commit && bank_committed(wbank_s)) begin
      cmd_err_d = 1'b1;
    end else if (wr_fire) begin
      wptr_d     = wptr_q + CW'(1);
      bs_d[wb_q] = FILL;
    end

    // Read side only ever touches a bank that is FULL or READ.
    case (rbank_s)
      FULL: begin
        bs_d[rb_q] = READ;
        rptr_d     = '0;
      end
      READ: begin
        if (rd_release) begin
          bs_d[rb_q] = EMPTY;
          rb_d       = ~rb_q;
          rptr_d     = '0;
        end else if (rd_rewind) begin
          rptr_d = '0;
        end else if (rd_fire) begin
          rptr_d = rptr_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bs_q[0]   <= EMPTY;
      bs_q[1]   <= EMPTY;
      len_q[0]  <= '0;
      len_q[1]  <= '0;
      wb_q      <= 1'b0;
      rb_q      <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cmd_err_q <= 1'b0;
    end else begin
      bs_q      <= bs_d;
      len_q     <= len_d;
      wb_q      <= wb_d;
      rb_q      <= rb_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  assign wr_count     = wptr_q;
  assign rd_tri       = rd_valid ? ram_rdata : '0;
  assign frames_ready = 2'(bank_committed(bs_q[0])) + 2'(bank_committed(bs_q[1]));
  assign cmd_err      = cmd_err_q;

endmodule
